// File: rtl/raymarch_step_controller.sv
// Sphere-tracing sequencer: marches one ray through an external SDF pipeline
// until it hits a surface, escapes the scene or runs out of step budget.
module raymarch_step_controller #(
   parameter int unsigned MAX_STEPS = 64,
   parameter int unsigned STEP_W    = 7,
   parameter logic [26:0] EPSILON   = 27'h1E11EB8,
   parameter logic [26:0] MAX_DIST  = 27'h2164000,
   parameter logic [26:0] MIN_DIST  = 27'h0000000
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [19:0]       in_tag_i,
   input  logic [26:0]       in_cam_x_i,
   input  logic [26:0]       in_cam_y_i,
   input  logic [26:0]       in_cam_z_i,
   input  logic [26:0]       in_dir_x_i,
   input  logic [26:0]       in_dir_y_i,
   input  logic [26:0]       in_dir_z_i,
   output logic              sdf_req_valid_o,
   output logic [26:0]       sdf_px_o,
   output logic [26:0]       sdf_py_o,
   output logic [26:0]       sdf_pz_o,
   input  logic              sdf_resp_valid_i,
   input  logic [26:0]       sdf_dist_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [19:0]       out_tag_o,
   output logic [1:0]        out_status_o,
   output logic [STEP_W-1:0] out_steps_o,
   output logic [26:0]       out_depth_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_EVAL,
      S_DONE
   } state_t;

   localparam logic [1:0] ST_HIT  = 2'b00;
   localparam logic [1:0] ST_ESC  = 2'b01;
   localparam logic [1:0] ST_EXH  = 2'b10;
   localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(MAX_STEPS);

   // Float add, truncating; exponent 0 is treated as zero, no inf/nan.
   function automatic logic [26:0] fadd(input logic [26:0] a,
                                        input logic [26:0] b);
      logic [26:0] x;
      logic [26:0] y;
      logic [26:0] r;
      logic [9:0]  e;
      logic [7:0]  sh;
      logic [19:0] mx;
      logic [19:0] my;
      logic [19:0] s;
      r = 27'd0;
      if (a[25:0] >= b[25:0]) begin
         x = a;
         y = b;
      end else begin
         x = b;
         y = a;
      end
      if (y[25:18] == 8'd0) begin
         r = x;
      end else begin
         e  = {2'b00, x[25:18]};
         sh = x[25:18] - y[25:18];
         mx = {2'b01, x[17:0]};
         my = (sh > 8'd19) ? 20'd0 : ({2'b01, y[17:0]} >> sh);
         s  = (x[26] == y[26]) ? (mx + my) : (mx - my);
         if (s != 20'd0) begin
            if (s[19]) begin
               s = s >> 1;
               e = e + 10'd1;
            end
            for (int i = 0; i < 19; i++) begin
               if (!s[18]) begin
                  s = s << 1;
                  e = e - 10'd1;
               end
            end
            if (e[9] || e == 10'd0)
               r = 27'd0;
            else if (e >= 10'd255)
               r = {x[26], 8'hFE, 18'h3FFFF};
            else
               r = {x[26], e[7:0], s[17:0]};
         end
      end
      return r;
   endfunction

   // Float multiply, truncating; flushes underflow to zero.
   function automatic logic [26:0] fmul(input logic [26:0] a,
                                        input logic [26:0] b);
      logic [26:0] r;
      logic [9:0]  e;
      logic [37:0] ma;
      logic [37:0] mb;
      logic [37:0] p;
      r = 27'd0;
      if (a[25:18] != 8'd0 && b[25:18] != 8'd0) begin
         ma = {19'd0, 1'b1, a[17:0]};
         mb = {19'd0, 1'b1, b[17:0]};
         p  = ma * mb;
         e  = {2'b00, a[25:18]} + {2'b00, b[25:18]} - 10'd127;
         if (p[37]) begin
            p = p >> 19;
            e = e + 10'd1;
         end else begin
            p = p >> 18;
         end
         if (e[9] || e == 10'd0)
            r = 27'd0;
         else if (e >= 10'd255)
            r = {a[26] ^ b[26], 8'hFE, 18'h3FFFF};
         else
            r = {a[26] ^ b[26], e[7:0], p[17:0]};
      end
      return r;
   endfunction

   state_t            state_q;
   logic [19:0]       tag_q;
   logic [26:0]       cam_x_q, cam_y_q, cam_z_q;
   logic [26:0]       dir_x_q, dir_y_q, dir_z_q;
   logic [26:0]       depth_q;
   logic [26:0]       dist_q;
   logic [STEP_W-1:0] steps_q;
   logic              in_ready_q;
   logic              sdf_req_valid_q;
   logic [26:0]       sdf_px_q, sdf_py_q, sdf_pz_q;
   logic              out_valid_q;
   logic [19:0]       out_tag_q;
   logic [1:0]        out_status_q;
   logic [STEP_W-1:0] out_steps_q;
   logic [26:0]       out_depth_q;

   logic [26:0] depth_sum_d;
   logic [26:0] pt_depth_d;
   logic [26:0] pt_cx_d, pt_cy_d, pt_cz_d;
   logic [26:0] pt_dx_d, pt_dy_d, pt_dz_d;
   logic [26:0] pt_x_d, pt_y_d, pt_z_d;
   logic        hit_d;
   logic        esc_d;
   logic        last_d;

   // Next sample point: from the incoming ray in IDLE, else the advanced depth.
   always_comb begin
      depth_sum_d = fadd(depth_q, dist_q);
      if (state_q == S_IDLE) begin
         pt_depth_d = MIN_DIST;
         pt_cx_d    = in_cam_x_i;
         pt_cy_d    = in_cam_y_i;
         pt_cz_d    = in_cam_z_i;
         pt_dx_d    = in_dir_x_i;
         pt_dy_d    = in_dir_y_i;
         pt_dz_d    = in_dir_z_i;
      end else begin
         pt_depth_d = depth_sum_d;
         pt_cx_d    = cam_x_q;
         pt_cy_d    = cam_y_q;
         pt_cz_d    = cam_z_q;
         pt_dx_d    = dir_x_q;
         pt_dy_d    = dir_y_q;
         pt_dz_d    = dir_z_q;
      end
      pt_x_d = fadd(pt_cx_d, fmul(pt_depth_d, pt_dx_d));
      pt_y_d = fadd(pt_cy_d, fmul(pt_depth_d, pt_dy_d));
      pt_z_d = fadd(pt_cz_d, fmul(pt_depth_d, pt_dz_d));
      hit_d  = dist_q[26] || (dist_q[25:0] < EPSILON[25:0]);
      esc_d  = depth_sum_d[25:0] >= MAX_DIST[25:0];
      last_d = steps_q == STEP_MAX;
   end

   // Ray sequencer FSM with all handshake and result outputs registered.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q         <= S_IDLE;
         tag_q           <= '0;
         cam_x_q         <= '0;
         cam_y_q         <= '0;
         cam_z_q         <= '0;
         dir_x_q         <= '0;
         dir_y_q         <= '0;
         dir_z_q         <= '0;
         depth_q         <= '0;
         dist_q          <= '0;
         steps_q         <= '0;
         in_ready_q      <= 1'b1;
         sdf_req_valid_q <= 1'b0;
         sdf_px_q        <= '0;
         sdf_py_q        <= '0;
         sdf_pz_q        <= '0;
         out_valid_q     <= 1'b0;
         out_tag_q       <= '0;
         out_status_q    <= '0;
         out_steps_q     <= '0;
         out_depth_q     <= '0;
      end else begin
         sdf_req_valid_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (in_valid_i) begin
                  tag_q           <= in_tag_i;
                  cam_x_q         <= in_cam_x_i;
                  cam_y_q         <= in_cam_y_i;
                  cam_z_q         <= in_cam_z_i;
                  dir_x_q         <= in_dir_x_i;
                  dir_y_q         <= in_dir_y_i;
                  dir_z_q         <= in_dir_z_i;
                  depth_q         <= MIN_DIST;
                  steps_q         <= '0;
                  sdf_px_q        <= pt_x_d;
                  sdf_py_q        <= pt_y_d;
                  sdf_pz_q        <= pt_z_d;
                  sdf_req_valid_q <= 1'b1;
                  in_ready_q      <= 1'b0;
                  state_q         <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (sdf_resp_valid_i) begin
                  dist_q <= sdf_dist_i;
                  if (steps_q != STEP_MAX)
                     steps_q <= steps_q + STEP_W'(1);
                  state_q <= S_EVAL;
               end
            end
            S_EVAL: begin
               if (hit_d) begin
                  out_status_q <= ST_HIT;
                  out_depth_q  <= depth_q;
                  out_tag_q    <= tag_q;
                  out_steps_q  <= steps_q;
                  out_valid_q  <= 1'b1;
                  state_q      <= S_DONE;
               end else if (esc_d || last_d) begin
                  depth_q      <= depth_sum_d;
                  out_status_q <= esc_d ? ST_ESC : ST_EXH;
                  out_depth_q  <= depth_sum_d;
                  out_tag_q    <= tag_q;
                  out_steps_q  <= steps_q;
                  out_valid_q  <= 1'b1;
                  state_q      <= S_DONE;
               end else begin
                  depth_q         <= depth_sum_d;
                  sdf_px_q        <= pt_x_d;
                  sdf_py_q        <= pt_y_d;
                  sdf_pz_q        <= pt_z_d;
                  sdf_req_valid_q <= 1'b1;
                  state_q         <= S_ISSUE;
               end
            end
            S_DONE: begin
               if (out_ready_i) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready_o      = in_ready_q;
   assign sdf_req_valid_o = sdf_req_valid_q;
   assign sdf_px_o        = sdf_px_q;
   assign sdf_py_o        = sdf_py_q;
   assign sdf_pz_o        = sdf_pz_q;
   assign out_valid_o     = out_valid_q;
   assign out_tag_o       = out_tag_q;
   assign out_status_o    = out_status_q;
   assign out_steps_o     = out_steps_q;
   assign out_depth_o     = out_depth_q;

endmodule

// File: tb/tb_raymarch_step_controller.sv
// Bench for raymarch_step_controller: latency-3 SDF model with a
// programmable distance sequence and a result scoreboard.
module tb_raymarch_step_controller;

   localparam logic [26:0] F0   = 27'h0000000;
   localparam logic [26:0] F1   = 27'h1FC0000;
   localparam logic [26:0] F2   = 27'h2000000;
   localparam logic [26:0] F3   = 27'h2020000;
   localparam logic [26:0] F4   = 27'h2040000;
   localparam logic [26:0] F7   = 27'h2070000;
   localparam logic [26:0] F64  = 27'h2140000;
   localparam logic [26:0] F100 = 27'h2164000;
   localparam logic [26:0] FM1  = 27'h5FC0000;
   localparam logic [26:0] F005 = 27'h1DD1EB8;

   logic        clk = 1'b0;
   logic        reset_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [19:0] in_tag_i;
   logic [26:0] in_cam_x_i, in_cam_y_i, in_cam_z_i;
   logic [26:0] in_dir_x_i, in_dir_y_i, in_dir_z_i;
   logic        sdf_req_valid_o;
   logic [26:0] sdf_px_o, sdf_py_o, sdf_pz_o;
   logic        sdf_resp_valid_i;
   logic [26:0] sdf_dist_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [19:0] out_tag_o;
   logic [1:0]  out_status_o;
   logic [6:0]  out_steps_o;
   logic [26:0] out_depth_o;

   raymarch_step_controller dut (
      .clk_i            (clk),
      .reset_i          (reset_i),
      .in_valid_i       (in_valid_i),
      .in_ready_o       (in_ready_o),
      .in_tag_i         (in_tag_i),
      .in_cam_x_i       (in_cam_x_i),
      .in_cam_y_i       (in_cam_y_i),
      .in_cam_z_i       (in_cam_z_i),
      .in_dir_x_i       (in_dir_x_i),
      .in_dir_y_i       (in_dir_y_i),
      .in_dir_z_i       (in_dir_z_i),
      .sdf_req_valid_o  (sdf_req_valid_o),
      .sdf_px_o         (sdf_px_o),
      .sdf_py_o         (sdf_py_o),
      .sdf_pz_o         (sdf_pz_o),
      .sdf_resp_valid_i (sdf_resp_valid_i),
      .sdf_dist_i       (sdf_dist_i),
      .out_valid_o      (out_valid_o),
      .out_ready_i      (out_ready_i),
      .out_tag_o        (out_tag_o),
      .out_status_o     (out_status_o),
      .out_steps_o      (out_steps_o),
      .out_depth_o      (out_depth_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // SDF model: fixed latency 3, first distance then a repeated second one
   logic [2:0]  v_pipe = 3'b000;
   logic [26:0] d0p = '0, d1p = '0, d2p = '0;
   logic [26:0] dseq0 = '0, dseq1 = '0;
   int          seq_base = 0;
   int          req_count = 0;
   logic [26:0] cur_d;

   always_comb cur_d = (req_count == seq_base) ? dseq0 : dseq1;

   always @(posedge clk) begin
      if (reset_i) begin
         v_pipe <= 3'b000;
      end else begin
         v_pipe <= {v_pipe[1:0], sdf_req_valid_o};
         d0p    <= cur_d;
         d1p    <= d0p;
         d2p    <= d1p;
         if (sdf_req_valid_o) req_count <= req_count + 1;
      end
   end

   assign sdf_resp_valid_i = v_pipe[2];
   assign sdf_dist_i       = d2p;

   // Strobe log
   int          strobes = 0;
   int          scyc [0:1023];
   logic [26:0] spx [0:1023];
   logic [26:0] spy [0:1023];
   logic [26:0] spz [0:1023];

   always @(negedge clk) begin
      if (sdf_req_valid_o && strobes < 1024) begin
         scyc[strobes] = cyc;
         spx[strobes]  = sdf_px_o;
         spy[strobes]  = sdf_py_o;
         spz[strobes]  = sdf_pz_o;
         strobes++;
      end
   end

   // Result scoreboard
   typedef struct {
      logic [19:0] tag;
      logic [1:0]  st;
      logic [6:0]  steps;
      logic [26:0] depth;
   } exp_t;
   exp_t sb_q[$];

   always @(negedge clk) begin
      exp_t e;
      if (out_valid_o && out_ready_i) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got tag %h expected none",
                     out_tag_o);
         end else begin
            e = sb_q.pop_front();
            chk("res_tag", 32'(out_tag_o), 32'(e.tag));
            chk("res_status", 32'(out_status_o), 32'(e.st));
            chk("res_steps", 32'(out_steps_o), 32'(e.steps));
            chk("res_depth", 32'(out_depth_o), 32'(e.depth));
         end
      end
   end

   task automatic push_exp(input logic [19:0] tag, input logic [1:0] st,
                           input logic [6:0] steps, input logic [26:0] dep);
      exp_t e;
      e.tag   = tag;
      e.st    = st;
      e.steps = steps;
      e.depth = dep;
      sb_q.push_back(e);
   endtask

   int s0 = 0;

   task automatic set_ray(input logic [19:0] tag,
                          input logic [26:0] cx, cy, cz, dx, dy, dz,
                          input logic [26:0] d0, d1);
      seq_base   = req_count;
      dseq0      = d0;
      dseq1      = d1;
      s0         = strobes;
      in_tag_i   = tag;
      in_cam_x_i = cx;
      in_cam_y_i = cy;
      in_cam_z_i = cz;
      in_dir_x_i = dx;
      in_dir_y_i = dy;
      in_dir_z_i = dz;
   endtask

   task automatic launch(input logic [19:0] tag,
                         input logic [26:0] cx, cy, cz, dx, dy, dz,
                         input logic [26:0] d0, d1);
      bit acc;
      int n;
      set_ray(tag, cx, cy, cz, dx, dy, dz, d0, d1);
      in_valid_i = 1'b1;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = in_ready_o;
         @(posedge clk);
         #1;
         n++;
      end
      in_valid_i = 1'b0;
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got in_ready 0 expected 1");
      end
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL result_timeout: got %0d pending expected 0",
                  sb_q.size());
         sb_q.delete();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int bad;
      int n;
      int hs;
      int acc;
      int k;
      reset_i     = 1'b1;
      in_valid_i  = 1'b0;
      out_ready_i = 1'b1;
      set_ray(20'h0, F0, F0, F0, F0, F0, F0, F0, F0);
      repeat (3) @(posedge clk);
      #1;
      reset_i = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready_o), 1);
      chk("rst_sdf_req", 32'(sdf_req_valid_o), 0);
      chk("rst_out_valid", 32'(out_valid_o), 0);
      chk("rst_out_tag", 32'(out_tag_o), 0);
      chk("rst_out_status", 32'(out_status_o), 0);
      chk("rst_out_steps", 32'(out_steps_o), 0);
      chk("rst_out_depth", 32'(out_depth_o), 0);
      chk("rst_sdf_px", 32'(sdf_px_o), 0);
      @(posedge clk);
      #1;

      // immediate hit
      push_exp(20'h00101, 2'b00, 7'd1, F0);
      launch(20'h00101, F0, F0, F0, F1, F0, F0, F005, F005);
      wait_done(200);
      chk("t1_strobes", 32'(strobes - s0), 1);

      // escape at 100.0
      push_exp(20'h00202, 2'b01, 7'd50, F100);
      launch(20'h00202, F0, F0, F0, F1, F0, F0, F2, F2);
      wait_done(1000);
      chk("t2_strobes", 32'(strobes - s0), 50);

      // step budget exhausted
      push_exp(20'h00303, 2'b10, 7'd64, F64);
      launch(20'h00303, F0, F0, F0, F1, F0, F0, F1, F1);
      wait_done(1000);
      chk("t3_strobes", 32'(strobes - s0), 64);
      chk("t3_gap0", 32'(scyc[s0 + 1] - scyc[s0]), 5);
      bad = 0;
      for (int i = 1; i < 64; i++)
         if (scyc[s0 + i] - scyc[s0 + i - 1] != 5) bad++;
      chk("t3_bad_gaps", 32'(bad), 0);

      // sample points follow the depth
      push_exp(20'h00404, 2'b00, 7'd2, F4);
      launch(20'h00404, F1, F2, F3, F0, F0, F1, F4, FM1);
      wait_done(200);
      chk("t4_strobes", 32'(strobes - s0), 2);
      chk("t4_p0x", 32'(spx[s0]), 32'(F1));
      chk("t4_p0y", 32'(spy[s0]), 32'(F2));
      chk("t4_p0z", 32'(spz[s0]), 32'(F3));
      chk("t4_p1x", 32'(spx[s0 + 1]), 32'(F1));
      chk("t4_p1y", 32'(spy[s0 + 1]), 32'(F2));
      chk("t4_p1z", 32'(spz[s0 + 1]), 32'(F7));

      // output backpressure
      out_ready_i = 1'b0;
      push_exp(20'h00505, 2'b00, 7'd1, F0);
      launch(20'h00505, F0, F0, F0, F1, F0, F0, F005, F005);
      n = 0;
      while (!out_valid_o && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("t5_out_valid_seen", 32'(out_valid_o), 1);
      in_tag_i   = 20'h00606;
      in_valid_i = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("t5_hold_valid", 32'(out_valid_o), 1);
         chk("t5_hold_tag", 32'(out_tag_o), 32'h00505);
         chk("t5_hold_status", 32'(out_status_o), 0);
         chk("t5_hold_steps", 32'(out_steps_o), 1);
         chk("t5_hold_depth", 32'(out_depth_o), 32'(F0));
         chk("t5_in_ready_low", 32'(in_ready_o), 0);
         @(posedge clk);
         #1;
      end
      push_exp(20'h00606, 2'b00, 7'd1, F0);
      set_ray(20'h00606, F0, F0, F0, F1, F0, F0, F005, F005);
      out_ready_i = 1'b1;
      @(negedge clk);
      hs = cyc;
      acc = -1;
      n = 0;
      while (acc < 0 && n < 20) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         if (in_valid_i && in_ready_o) acc = cyc;
         n++;
      end
      @(posedge clk);
      #1;
      in_valid_i = 1'b0;
      chk("t5_accept_after_hs", 32'(acc > hs), 1);
      wait_done(200);

      // reset during WAIT discards the ray
      launch(20'h00707, F0, F0, F0, F1, F0, F0, F1, F1);
      n = 0;
      while (strobes == s0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      reset_i = 1'b1;
      @(posedge clk);
      #1;
      reset_i = 1'b0;
      @(negedge clk);
      chk("t6_in_ready", 32'(in_ready_o), 1);
      chk("t6_out_valid", 32'(out_valid_o), 0);
      chk("t6_sdf_req", 32'(sdf_req_valid_o), 0);
      chk("t6_out_steps", 32'(out_steps_o), 0);
      k = strobes;
      repeat (30) @(posedge clk);
      #1;
      chk("t6_no_strobe", 32'(strobes - k), 0);

      // recovery after reset
      push_exp(20'h00808, 2'b00, 7'd2, F4);
      launch(20'h00808, F1, F2, F3, F0, F0, F1, F4, FM1);
      wait_done(200);
      chk("t7_p1z", 32'(spz[s0 + 1]), 32'(F7));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
